// File: rtl/exhaustive_pattern_checker_pkg.sv
// Shared types and constants for the exhaustive pattern checker.
//   state_e : checker FSM states
//   N_IN_DEFAULT / N_PAT / CNT_W : sizes for the default 4-input build
//   HOLD_W  : width of the hold-window counter (HOLD up to 255)
package exhaustive_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  localparam int unsigned N_IN_DEFAULT = 4;
  localparam int unsigned N_PAT        = 2 ** N_IN_DEFAULT;
  localparam int unsigned CNT_W        = N_IN_DEFAULT + 1;
  localparam int unsigned HOLD_W       = 8;

endpackage

// File: rtl/exhaustive_pattern_checker_if.sv
// Bundle of the checker's run-control, stimulus and result signals.
//   master : the checker (drives pattern and results, receives start/exp_tt/dut_out)
//   slave  : the board or bench side
interface exhaustive_pattern_checker_if #(
  parameter int unsigned N_IN = 4
);

  logic                   start;
  logic [2**N_IN-1:0]     exp_tt;
  logic                   dut_out;
  logic [N_IN-1:0]        pattern;
  logic                   pat_valid;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_err_idx;
  logic                   first_err_valid;

  modport master (
    input  start, exp_tt, dut_out,
    output pattern, pat_valid, busy, done, pass, err_count, first_err_idx, first_err_valid
  );

  modport slave (
    output start, exp_tt, dut_out,
    input  pattern, pat_valid, busy, done, pass, err_count, first_err_idx, first_err_valid
  );

endinterface

// File: rtl/exhaustive_pattern_checker_timer.sv
// Hold-window timer: counts 0..HOLD-1 while enabled and raises `last` in the final
// cycle of each window, which the checker uses as its sample strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (start of a run)
//   enable     : count this cycle
//   last       : enable && count == HOLD-1
module pattern_hold_timer
  import exhaustive_pkg::*;
#(
  parameter int unsigned HOLD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [HOLD_W-1:0] LastCnt = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              at_end;

  assign at_end = (cnt_q == LastCnt);
  assign last   = enable && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exhaustive_pattern_checker.sv
// Exhaustive pattern checker: drives every N_IN-bit pattern in ascending order,
// holds each for HOLD cycles, samples dut_out in the last cycle of the window and
// scores it against a truth table captured at start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/exp_tt/dut_out in; pattern, pat_valid, busy, done, pass,
//                err_count, first_err_idx, first_err_valid out
module exhaustive_pattern_checker
  import exhaustive_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned HOLD = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  exhaustive_pattern_checker_if.master bus
);

  localparam logic [N_IN-1:0] LastPat = '1;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    pattern_q, pattern_d;
  logic [2**N_IN-1:0] exp_q, exp_d;
  logic [N_IN:0]      err_q, err_d;
  logic [N_IN-1:0]    first_idx_q, first_idx_d;
  logic               first_valid_q, first_valid_d;
  logic               pass_q, pass_d;
  logic               timer_clear, timer_en, sample;
  logic               mismatch;

  pattern_hold_timer #(
    .HOLD (HOLD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .last   (sample)
  );

  assign mismatch = (bus.dut_out != exp_q[pattern_q]);

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    exp_d         = exp_q;
    err_d         = err_q;
    first_idx_d   = first_idx_q;
    first_valid_d = first_valid_q;
    pass_d        = pass_q;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d       = StDrive;
          exp_d         = bus.exp_tt;
          err_d         = '0;
          first_idx_d   = '0;
          first_valid_d = 1'b0;
          pass_d        = 1'b0;
          pattern_d     = '0;
          timer_clear   = 1'b1;
        end
      end
      StDrive: begin
        // start is deliberately ignored here; only the captured table is used
        timer_en = 1'b1;
        if (sample) begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!first_valid_q) begin
              first_idx_d   = pattern_q;
              first_valid_d = 1'b1;
            end
          end
          if (pattern_q == LastPat) begin
            state_d   = StDone;
            pattern_d = '0;
            // err_d already includes the final sample
            pass_d    = (err_d == '0);
          end else begin
            pattern_d = pattern_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pattern_q     <= '0;
      exp_q         <= '0;
      err_q         <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      exp_q         <= exp_d;
      err_q         <= err_d;
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
      pass_q        <= pass_d;
    end
  end

  assign bus.pattern         = pattern_q;
  assign bus.pat_valid       = (state_q == StDrive);
  assign bus.busy            = (state_q == StDrive);
  assign bus.done            = (state_q == StDone);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_idx   = first_idx_q;
  assign bus.first_err_valid = first_valid_q;

endmodule

// File: tb/tb_exhaustive_pattern_checker.sv
module tb_exhaustive_pattern_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exhaustive_pattern_checker_if #(.N_IN(4)) u_if0 ();
  exhaustive_pattern_checker_if #(.N_IN(4)) u_if1 ();

  exhaustive_pattern_checker #(.N_IN(4), .HOLD(20)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if0)
  );

  exhaustive_pattern_checker #(.N_IN(4), .HOLD(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1)
  );

  // Model DUT for the HOLD=20 checker: 0 = AND4, 1 = high on 5 and 15, 2 = tied 0
  int mode0 = 0;
  always_comb begin
    case (mode0)
      0:       u_if0.dut_out = &u_if0.pattern;
      1:       u_if0.dut_out = (u_if0.pattern == 4'd5) || (u_if0.pattern == 4'd15);
      default: u_if0.dut_out = 1'b0;
    endcase
  end
  // Model DUT for the HOLD=1 checker: NOR4
  always_comb u_if1.dut_out = ~|u_if1.pattern;

  int checks = 0;
  int failures = 0;

  // Start a run on checker 0; returns cycles from the accepting edge to done.
  task automatic run0(input logic [15:0] tt, input int chk_cyc, input logic [3:0] chk_pat,
                      input int mid_start, output int n);
    @(negedge clk);
    u_if0.exp_tt = tt;
    u_if0.start  = 1'b1;
    @(posedge clk);
    #1;
    u_if0.start  = 1'b0;
    u_if0.exp_tt = ~tt;  // must not affect the run
    checks++;
    if (u_if0.busy !== 1'b1 || u_if0.pat_valid !== 1'b1 || u_if0.pattern !== 4'd0 ||
        u_if0.done !== 1'b0 || u_if0.err_count !== 5'd0 || u_if0.pass !== 1'b0 ||
        u_if0.first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_accept: busy=%b pv=%b pat=%0d done=%b err=%0d pass=%b fv=%b, need 1 1 0 0 0 0 0",
               u_if0.busy, u_if0.pat_valid, u_if0.pattern, u_if0.done, u_if0.err_count,
               u_if0.pass, u_if0.first_err_valid);
    end
    n = 0;
    while (n < 1000 && u_if0.done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      u_if0.start = 1'b0;
      if (n == chk_cyc) begin
        checks++;
        if (u_if0.pattern !== chk_pat) begin
          failures++;
          $display("FAIL pattern_step: cycle %0d pattern=%0d need %0d", n, u_if0.pattern, chk_pat);
        end
      end
      if (n == mid_start) u_if0.start = 1'b1;
    end
  endtask

  task automatic check_result0(input string name, input int n, input logic [4:0] err,
                               input logic pass, input logic fv, input logic [3:0] idx);
    checks++;
    if (n != 320 || u_if0.err_count !== err || u_if0.pass !== pass ||
        u_if0.first_err_valid !== fv || (fv && u_if0.first_err_idx !== idx) ||
        u_if0.busy !== 1'b0 || u_if0.pat_valid !== 1'b0 || u_if0.pattern !== 4'd0) begin
      failures++;
      $display("FAIL %s: cycles=%0d err=%0d pass=%b fv=%b idx=%0d busy=%b pat=%0d, need 320 %0d %b %b %0d 0 0",
               name, n, u_if0.err_count, u_if0.pass, u_if0.first_err_valid,
               u_if0.first_err_idx, u_if0.busy, u_if0.pattern, err, pass, fv, idx);
    end
  endtask

  task automatic test_reset();
    u_if0.start = 1'b0; u_if0.exp_tt = '0;
    u_if1.start = 1'b0; u_if1.exp_tt = '0;
    #1;
    checks++;
    if ({u_if0.pattern, u_if0.pat_valid, u_if0.busy, u_if0.done, u_if0.pass, u_if0.err_count,
         u_if0.first_err_idx, u_if0.first_err_valid} !== '0 ||
        {u_if1.busy, u_if1.done, u_if1.pattern} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b pat=%0d err=%0d, need all 0",
               u_if0.busy, u_if0.done, u_if0.pattern, u_if0.err_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (u_if0.busy !== 1'b0 || u_if0.done !== 1'b0 || u_if0.pat_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b pv=%b, need 0 0 0",
               u_if0.busy, u_if0.done, u_if0.pat_valid);
    end
  endtask

  task automatic test_all_correct();
    int n;
    mode0 = 0;
    run0(16'h8000, 20, 4'd1, -1, n);
    check_result0("all_correct", n, 5'd0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_single_fault();
    int n;
    mode0 = 1;
    run0(16'h8000, 119, 4'd5, -1, n);
    check_result0("single_fault", n, 5'd1, 1'b0, 1'b1, 4'd5);
  endtask

  task automatic test_all_wrong();
    int n;
    mode0 = 2;
    run0(16'hFFFF, 320, 4'd0, -1, n);
    check_result0("all_wrong", n, 5'b10000, 1'b0, 1'b1, 4'd0);
  endtask

  // Restart from DONE (previous run left err_count=16) with a start pulse mid-run
  task automatic test_restart_ignored_start();
    int n;
    checks++;
    if (u_if0.done !== 1'b1 || u_if0.err_count !== 5'd16) begin
      failures++;
      $display("FAIL done_hold: done=%b err=%0d, need 1 16", u_if0.done, u_if0.err_count);
    end
    mode0 = 0;
    run0(16'h8000, 100, 4'd5, 100, n);
    check_result0("ignored_start", n, 5'd0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_reset_mid_run();
    int n;
    mode0 = 2;
    @(negedge clk);
    u_if0.exp_tt = 16'hFFFF;
    u_if0.start  = 1'b1;
    @(negedge clk);
    u_if0.start  = 1'b0;
    n = 0;
    while (n < 1000 && u_if0.pattern !== 4'd7) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (u_if0.pattern !== 4'd7 || u_if0.err_count !== 5'd7) begin
      failures++;
      $display("FAIL reach_pattern7: pat=%0d err=%0d, need 7 7", u_if0.pattern, u_if0.err_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({u_if0.pattern, u_if0.pat_valid, u_if0.busy, u_if0.done, u_if0.pass, u_if0.err_count,
         u_if0.first_err_idx, u_if0.first_err_valid} !== '0) begin
      failures++;
      $display("FAIL async_reset: pat=%0d busy=%b err=%0d fv=%b, need all 0",
               u_if0.pattern, u_if0.busy, u_if0.err_count, u_if0.first_err_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (u_if0.busy !== 1'b0 || u_if0.done !== 1'b0 || u_if0.pattern !== 4'd0 ||
        u_if0.err_count !== 5'd0) begin
      failures++;
      $display("FAIL idle_after_abort: busy=%b done=%b pat=%0d err=%0d, need 0 0 0 0",
               u_if0.busy, u_if0.done, u_if0.pattern, u_if0.err_count);
    end
  endtask

  task automatic test_hold1();
    int n;
    @(negedge clk);
    u_if1.exp_tt = 16'h0001;
    u_if1.start  = 1'b1;
    @(posedge clk);
    #1;
    u_if1.start  = 1'b0;
    u_if1.exp_tt = 16'h0000;
    n = 0;
    while (n < 1000 && u_if1.done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) begin
        checks++;
        if (u_if1.pattern !== 4'd3) begin
          failures++;
          $display("FAIL hold1_step: pattern=%0d need 3", u_if1.pattern);
        end
      end
    end
    checks++;
    if (n != 16 || u_if1.pass !== 1'b1 || u_if1.err_count !== 5'd0 ||
        u_if1.first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold1_result: cycles=%0d pass=%b err=%0d fv=%b, need 16 1 0 0",
               n, u_if1.pass, u_if1.err_count, u_if1.first_err_valid);
    end
  endtask

  initial begin
    test_reset();
    test_all_correct();
    test_single_fault();
    test_all_wrong();
    test_restart_ignored_start();
    test_reset_mid_run();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exhaustive_pattern_checker.md
Name: exhaustive_pattern_checker

Overview:
- Hardware counterpart of the exhaustive stimulus benches used for the combinational exercises.
- Drives every N_IN-bit input pattern in ascending order, holding each one for HOLD cycles.
- Samples the 1-bit DUT response at the end of each hold window and compares it with an expected truth table.
- Reports a mismatch count, the index of the first failing pattern, and pass/done status. Sits beside a combinational DUT on the lab board or in a self-checking bench.

Parameters:
- N_IN, 4, number of DUT inputs; pattern[N_IN-1] is the first input (a), pattern[0] the last (d).
- HOLD, 20, cycles each pattern is held; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when in IDLE or DONE.
- exp_tt  input  2**N_IN  expected truth table; bit i is the expected dut_out for pattern i; captured on accepted start.
- dut_out  input  1  DUT response, e.g. output e.
- pattern  output  N_IN  current stimulus to the DUT inputs.
- pat_valid  output  1  high while pattern is being driven.
- busy  output  1  high from accepted start until done.
- done  output  1  high in DONE; held until the next accepted start.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  N_IN+1  number of mismatching patterns, range 0..2**N_IN; cannot overflow.
- first_err_idx  output  N_IN  index of the first mismatching pattern.
- first_err_valid  output  1  1 once any mismatch has been recorded in the current run.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: pattern, pat_valid, busy, done, pass, err_count, first_err_idx, first_err_valid.
  - The captured exp_tt register goes to 0.
- States:
  - IDLE -> DRIVE on start.
  - DRIVE -> DRIVE while patterns remain.
  - DRIVE -> DONE after the last pattern is sampled.
  - DONE -> DRIVE on start.
  - DONE remains until start.
- Accepted start at edge t:
  - Captures exp_tt.
  - Clears err_count, first_err_idx, first_err_valid, done and pass.
  - Sets busy=1, pat_valid=1, pattern=0, hold_cnt=0.
- DRIVE:
  - hold_cnt counts 0..HOLD-1.
  - dut_out is sampled on the edge where hold_cnt==HOLD-1, which gives HOLD-1 cycles of settling. With HOLD=1, the sample is taken in the same cycle the pattern is applied.
  - Mismatch means dut_out != exp_tt[pattern]. On a mismatch, err_count increments. If first_err_valid==0, the checker also records first_err_idx=pattern and sets first_err_valid=1.
  - On the same sampling edge, if pattern != 2**N_IN-1: pattern increments and hold_cnt resets to 0.
  - On the same sampling edge, if pattern == 2**N_IN-1: go to DONE and set busy=0, pat_valid=0, done=1. pass takes err_count==0, including the final sample's result. pattern returns to 0 (no wrap-around drive).
- Latency:
  - done rises 2**N_IN*HOLD cycles after the accepted start edge.
  - Default: 320 cycles.
- start while busy is ignored, with no effect on the run.
- start and the final sample never coincide; start is only accepted in IDLE/DONE.
- Reset mid-run aborts immediately to IDLE with all outputs 0. A new start is required.
- exp_tt changes during a run have no effect; only the captured copy is used.
- dut_out is assumed synchronous to clk. No synchroniser is included; board use requires an external one.

Decomposition:
- Package exhaustive_pkg:
  - State enum: IDLE, DRIVE, DONE.
  - Localparams: N_PAT = 2**N_IN, CNT_W = N_IN+1, HOLD_W = 8.
- Sub-module pattern_hold_timer:
  - HOLD-cycle down/up counter.
  - Inputs: clear and enable.
  - Output: last-cycle strobe, which becomes the sample strobe.
- The top level holds the FSM, the pattern counter and the compare/score logic.

Test Plan:
- All correct: exp_tt=16'h8000 with DUT = 4-input AND, start -> pattern steps 0..15 every 20 cycles; done at +320 cycles; pass=1; err_count=0; first_err_valid=0.
- Single fault: exp_tt=16'h8000, DUT drives 1 only on pattern 5 and 15 -> err_count=1, first_err_idx=5, first_err_valid=1, pass=0.
- All wrong: exp_tt=16'hFFFF, DUT tied 0 -> err_count=16 (5'b10000, full width), first_err_idx=0, pass=0.
- Ignored start and restart:
  - Pulse start at cycle 100 of a run -> done timing is unchanged (+320 from the first start).
  - Start pulsed in DONE clears err_count/done at the next edge and reruns from pattern=0.
- Reset mid-run: drop rst_n at pattern=7 -> all outputs 0 asynchronously; after release, outputs stay in IDLE until start.
- HOLD=1 build: exp_tt=16'h0001 with DUT = NOR4 -> pattern changes every cycle; done 16 cycles after start; pass=1.
